// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Sysbus tag fields fall back to local definitions when Sysbus.defs is not in the build.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

package fetch_pkg;

   typedef enum logic [2:0] {
      START,
      REQ,
      FILL,
      DRAIN,
      HALT
   } fetch_state_t;

   localparam int LINE_BYTES = 64;
   localparam int LINE_OFF_W = $clog2(LINE_BYTES);
   localparam int WORD_IDX_W = 4;
   localparam int BEAT_IDX_W = 3;

   // Read of ordinary memory; the low tag bits are left zero.
   localparam logic [12:0] FETCH_REQ_TAG = {`SYSBUS_READ, `SYSBUS_MEMORY, 8'b0};

endpackage

// File: rtl/fetch_line_buffer.sv
// One cache line held as 8 x 64-bit beats, written a beat at a time and
// read back as 32-bit instruction words.
module fetch_line_buffer
   import fetch_pkg::*;
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [BEAT_IDX_W-1:0] widx,
   input  logic [63:0]           wdata,
   input  logic [WORD_IDX_W-1:0] ridx,
   output logic [31:0]           rdata
);

   logic [63:0] mem [0:(1<<BEAT_IDX_W)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[widx] <= wdata;
   end

   // Even words sit in the low half of a beat, odd words in the high half.
   always_comb begin
      rdata = ridx[0] ? mem[ridx[WORD_IDX_W-1:1]][63:32]
                      : mem[ridx[WORD_IDX_W-1:1]][31:0];
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fills one 64-byte line over Sysbus, then streams
// its words downstream. Optional trace output when FETCH_TRACE_EN is defined.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int LINE_BEATS     = 8
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               entry,
   output logic                      bus_reqcyc,
   input  logic                      bus_reqack,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_respcyc,
   output logic                      bus_respack,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [31:0]               instruction,
   output logic [63:0]               instr_pc,
   input  logic                      redirect,
   input  logic [63:0]               redirect_pc,
   output logic                      done
);

   fetch_state_t              state;
   logic [63:0]               pc;
   logic [63:LINE_OFF_W]      req_line;
   logic [BEAT_IDX_W-1:0]     beat_cnt;
   logic                      redirect_pending;

   logic [31:0]               cur_word;
   logic                      in_drain;
   logic                      word_is_zero;
   logic                      handshake;
   logic                      last_beat;
   logic [63:0]               redir_pc;
   logic [63:0]               pc_inc;
   logic                      unused_bits;

   assign unused_bits = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

   fetch_line_buffer u_line_buffer (
      .clk   (clk),
      .we    (bus_respack),
      .widx  (beat_cnt),
      .wdata (bus_resp),
      .ridx  (pc[LINE_OFF_W-1:2]),
      .rdata (cur_word)
   );

   // A zero word is never offered downstream; it only triggers the halt.
   always_comb begin
      in_drain     = (state == DRAIN);
      word_is_zero = (cur_word == 32'h0);
      instr_valid  = in_drain && !word_is_zero;
      handshake    = instr_valid && instr_ready;
      instruction  = in_drain ? cur_word : 32'h0;
      instr_pc     = in_drain ? pc : 64'h0;
      bus_reqcyc   = (state == REQ);
      bus_req      = bus_reqcyc ? {req_line, {LINE_OFF_W{1'b0}}} : '0;
      bus_reqtag   = bus_reqcyc ? FETCH_REQ_TAG : '0;
      bus_respack  = (state == FILL) && bus_respcyc;
      done         = (state == HALT);
      last_beat    = (beat_cnt == BEAT_IDX_W'(LINE_BEATS - 1));
      redir_pc     = {redirect_pc[63:2], 2'b00};
      pc_inc       = pc + 64'd4;
   end

   // The request address lives in req_line so pc can take a redirect while
   // a request is still waiting for its ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= START;
         pc               <= 64'h0;
         req_line         <= '0;
         beat_cnt         <= '0;
         redirect_pending <= 1'b0;
      end else begin
         case (state)
            START: begin
               pc       <= {entry[63:2], 2'b00};
               req_line <= entry[63:LINE_OFF_W];
               state    <= REQ;
            end
            REQ: begin
               if (redirect) begin
                  pc               <= redir_pc;
                  redirect_pending <= 1'b1;
               end
               if (bus_reqack) begin
                  beat_cnt <= '0;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (redirect) begin
                  pc               <= redir_pc;
                  redirect_pending <= 1'b1;
               end
               if (bus_respcyc) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     if (redirect_pending || redirect) begin
                        redirect_pending <= 1'b0;
                        req_line <= redirect ? redir_pc[63:LINE_OFF_W] : pc[63:LINE_OFF_W];
                        state    <= REQ;
                     end else begin
                        state <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               if (redirect) begin
                  pc <= redir_pc;
                  if (redir_pc[63:LINE_OFF_W] != pc[63:LINE_OFF_W]) begin
                     req_line <= redir_pc[63:LINE_OFF_W];
                     state    <= REQ;
                  end
               end else if (word_is_zero) begin
                  state <= HALT;
               end else if (handshake) begin
                  pc <= pc_inc;
                  if (pc_inc[LINE_OFF_W-1:0] == '0) begin
                     req_line <= pc_inc[63:LINE_OFF_W];
                     state    <= REQ;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= START;
            end
         endcase
      end
   end

`ifdef FETCH_TRACE_EN
   always @(posedge clk) begin
      if (reset) begin
         if (handshake)
            $display("fetch %h: %h", instr_pc, instruction);
         if (in_drain && word_is_zero && !redirect)
            $display("fetch halt");
      end
   end
`else
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a hand-driven Sysbus responder plus
// checks on the instruction stream, redirects, halt and reset.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [63:0] entry;
   logic        bus_reqcyc;
   logic        bus_reqack;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_respcyc;
   logic        bus_respack;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [63:0] instr_pc;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        done;

   int          checks = 0;
   int          fails  = 0;
   logic [63:0] zero_addr = 64'hFFFF_FFFF_FFFF_FFF0;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .entry       (entry),
      .bus_reqcyc  (bus_reqcyc),
      .bus_reqack  (bus_reqack),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_respcyc (bus_respcyc),
      .bus_respack (bus_respack),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .instr_pc    (instr_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: word at 0x1000+4i holds 0x100+i, with one optional hole of zero.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == zero_addr)
         return 32'h0;
      return 32'h100 + 32'((a - 64'h1000) >> 2);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyReset(input logic [63:0] start_pc);
      reset       = 1'b0;
      entry       = start_pc;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      redirect    = 1'b0;
      instr_ready = 1'b1;
      @(negedge clk);
      checkOutput("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
      checkOutput("rst_req", bus_req, 64'h0);
      checkOutput("rst_reqtag", 64'(bus_reqtag), 64'h0);
      checkOutput("rst_valid", 64'(instr_valid), 64'd0);
      checkOutput("rst_instr", 64'(instruction), 64'h0);
      checkOutput("rst_pc", instr_pc, 64'h0);
      checkOutput("rst_done", 64'(done), 64'd0);
      reset = 1'b1;
   endtask

   // Wait for a request, check it stays stable, ack it and return nbeats beats.
   task automatic applyStimulus(input logic [63:0] exp_addr, input int nbeats,
                                input int redir_beat, input logic [63:0] redir_target);
      for (int k = 0; k < 20 && !bus_reqcyc; k++)
         @(negedge clk);
      checkOutput("req_seen", 64'(bus_reqcyc), 64'd1);
      checkOutput("req_addr", bus_req, exp_addr);
      checkOutput("req_tag", 64'(bus_reqtag), 64'h1100);
      @(negedge clk);
      checkOutput("req_hold", bus_req, exp_addr);
      bus_reqack = 1'b1;
      @(negedge clk);
      bus_reqack = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         bus_respcyc = 1'b1;
         bus_resp    = {mem_word(exp_addr + 64'(8*b + 4)), mem_word(exp_addr + 64'(8*b))};
         if (b == redir_beat) begin
            redirect    = 1'b1;
            redirect_pc = redir_target;
         end
         #1;
         checkOutput("beat_ack", 64'(bus_respack), 64'd1);
         @(negedge clk);
         redirect = 1'b0;
      end
      bus_respcyc = 1'b0;
   endtask

   task automatic drainCheck(input logic [63:0] pc0, input int n);
      for (int i = 0; i < n; i++) begin
         checkOutput("drain_valid", 64'(instr_valid), 64'd1);
         checkOutput("drain_pc", instr_pc, pc0 + 64'(4*i));
         checkOutput("drain_instr", 64'(instruction), 64'(mem_word(pc0 + 64'(4*i))));
         checkOutput("drain_noreq", 64'(bus_reqcyc), 64'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus_resp    = 64'h0;
      bus_resptag = 13'h0;
      redirect_pc = 64'h0;

      $display("[TB] full line from entry 0x1000");
      applyReset(64'h1000);
      applyStimulus(64'h1000, 8, -1, 64'h0);
      drainCheck(64'h1000, 16);
      applyStimulus(64'h1040, 8, -1, 64'h0);
      drainCheck(64'h1040, 2);

      $display("[TB] entry mid-line 0x1038");
      applyReset(64'h1038);
      applyStimulus(64'h1000, 8, -1, 64'h0);
      drainCheck(64'h1038, 2);
      applyStimulus(64'h1040, 8, -1, 64'h0);

      $display("[TB] stall, then in-line redirect");
      applyReset(64'h1000);
      applyStimulus(64'h1000, 8, -1, 64'h0);
      drainCheck(64'h1000, 2);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall_pc", instr_pc, 64'h1008);
         checkOutput("stall_instr", 64'(instruction), 64'h102);
         @(negedge clk);
      end
      instr_ready = 1'b1;
      drainCheck(64'h1008, 2);
      redirect    = 1'b1;
      redirect_pc = 64'h1022;
      @(negedge clk);
      redirect = 1'b0;
      drainCheck(64'h1020, 2);

      $display("[TB] redirect during fill");
      applyReset(64'h1000);
      applyStimulus(64'h1000, 8, 3, 64'h2004);
      applyStimulus(64'h2000, 8, -1, 64'h0);
      drainCheck(64'h2004, 2);

      $display("[TB] halt on zero word");
      zero_addr = 64'h1010;
      applyReset(64'h1000);
      applyStimulus(64'h1000, 8, -1, 64'h0);
      drainCheck(64'h1000, 4);
      checkOutput("zero_valid", 64'(instr_valid), 64'd0);
      @(negedge clk);
      checkOutput("halt_done", 64'(done), 64'd1);
      checkOutput("halt_valid", 64'(instr_valid), 64'd0);
      redirect    = 1'b1;
      redirect_pc = 64'h3000;
      @(negedge clk);
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("halt_stay", 64'(done), 64'd1);
         checkOutput("halt_noreq", 64'(bus_reqcyc), 64'd0);
         @(negedge clk);
      end
      zero_addr = 64'hFFFF_FFFF_FFFF_FFF0;

      $display("[TB] reset during fill");
      applyReset(64'h1000);
      applyStimulus(64'h1000, 4, -1, 64'h0);
      bus_respcyc = 1'b1;
      reset       = 1'b0;
      #1;
      checkOutput("midrst_respack", 64'(bus_respack), 64'd0);
      checkOutput("midrst_reqcyc", 64'(bus_reqcyc), 64'd0);
      checkOutput("midrst_req", bus_req, 64'h0);
      checkOutput("midrst_valid", 64'(instr_valid), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("stray_respack", 64'(bus_respack), 64'd0);
      checkOutput("rereq_cyc", 64'(bus_reqcyc), 64'd1);
      bus_respcyc = 1'b0;
      applyStimulus(64'h1000, 8, -1, 64'h0);
      drainCheck(64'h1000, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
